mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction fetch (port 0) and load/store
//  (port 1). Grants one requester at a time and holds the grant until the memory completes.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_mux2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module : mem_port_arbiter_pkg
// Brief  : Shared state encoding, port indices and tie-break helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    // A lone requester always wins; ties go to LSU or to the port not served last.
    function automatic logic pick_winner(
        input logic req0,
        input logic req1,
        input logic last,
        input logic fixed_prio
    );
        logic win;
        if (req0 && req1) begin
            win = fixed_prio ? PORT_LSU : ~last;
        end else begin
            win = req1 ? PORT_LSU : PORT_FETCH;
        end
        return win;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_mux2.sv
// ============================================================================
// Module : mem_port_arbiter_mux2
// Brief  : Width-configurable 2:1 select used for the shared memory port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter_mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_in0,
    input  logic [WIDTH-1:0] i_in1,
    output logic [WIDTH-1:0] o_out
);

    assign o_out = i_sel ? i_in1 : i_in0;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Two-port (fetch / load-store) arbiter onto one memory port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  we0,
    input  logic [BUS_WIDTH-1:0]  wdata0,
    output logic                  ack0,
    output logic [BUS_WIDTH-1:0]  rdata0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  we1,
    input  logic [BUS_WIDTH-1:0]  wdata1,
    output logic                  ack1,
    output logic [BUS_WIDTH-1:0]  rdata1,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    input  logic                  mem_ready,
    input  logic [BUS_WIDTH-1:0]  mem_rdata
);

    localparam logic c_fixed_prio = (FIXED_PRIO != 0);

    logic [0:0] r_state;
    logic       r_grant;
    logic       r_last;
    logic       w_busy;
    logic       w_winner;
    logic       w_mux_we;

    assign w_busy   = (r_state == ST_BUSY);
    assign w_winner = pick_winner(req0, req1, r_last, c_fixed_prio);

    // Grant is only re-evaluated in IDLE, so the muxes stay put for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= PORT_FETCH;
            r_last  <= PORT_LSU;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_grant <= w_winner;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        r_last  <= r_grant;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mem_port_arbiter_mux2 #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
        .i_sel (r_grant),
        .i_in0 (addr0),
        .i_in1 (addr1),
        .o_out (mem_addr)
    );

    mem_port_arbiter_mux2 #(.WIDTH(BUS_WIDTH)) u_wdata_mux (
        .i_sel (r_grant),
        .i_in0 (wdata0),
        .i_in1 (wdata1),
        .o_out (mem_wdata)
    );

    mem_port_arbiter_mux2 #(.WIDTH(1)) u_we_mux (
        .i_sel (r_grant),
        .i_in0 (we0),
        .i_in1 (we1),
        .o_out (w_mux_we)
    );

    assign mem_req = w_busy;
    assign mem_we  = w_busy & w_mux_we;
    assign ack0    = w_busy & mem_ready & (r_grant == PORT_FETCH);
    assign ack1    = w_busy & mem_ready & (r_grant == PORT_LSU);
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Scoreboard bench driving a round-robin and a fixed-priority arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, req0, we0, req1, we1, mem_ready;
    logic [31:0] addr0, wdata0, addr1, wdata1, mem_rdata;

    logic        rr_ack0, rr_ack1, rr_mem_req, rr_mem_we;
    logic [31:0] rr_rdata0, rr_rdata1, rr_mem_addr, rr_mem_wdata;
    logic        fp_ack0, fp_ack1, fp_mem_req, fp_mem_we;
    logic [31:0] fp_rdata0, fp_rdata1, fp_mem_addr, fp_mem_wdata;

    int   checks   = 0;
    int   failures = 0;
    exp_t q_rr[$];
    exp_t q_fp[$];
    logic m_last_rr, m_last_fp;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .BUS_WIDTH(32), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .ack0(rr_ack0), .rdata0(rr_rdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .ack1(rr_ack1), .rdata1(rr_rdata1),
        .mem_req(rr_mem_req), .mem_addr(rr_mem_addr), .mem_we(rr_mem_we), .mem_wdata(rr_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .BUS_WIDTH(32), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .ack0(fp_ack0), .rdata0(fp_rdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .ack1(fp_ack1), .rdata1(fp_rdata1),
        .mem_req(fp_mem_req), .mem_addr(fp_mem_addr), .mem_we(fp_mem_we), .mem_wdata(fp_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_win(input logic r0, input logic r1, input logic last, input logic fp);
        if (r0 && r1) return fp ? 1'b1 : ~last;
        return r1;
    endfunction

    function automatic exp_t mk(input logic w, input logic [31:0] rd);
        exp_t e;
        e.port  = w;
        e.addr  = w ? addr1 : addr0;
        e.we    = w ? we1 : we0;
        e.wdata = w ? wdata1 : wdata0;
        e.rdata = rd;
        return e;
    endfunction

    task automatic check_ack(input string who, input logic a0, input logic a1,
                             input logic [31:0] maddr, input logic mwe, input logic [31:0] mwd,
                             input logic [31:0] r0, input logic [31:0] r1,
                             input bit have, input exp_t e);
        check({who, "_ack_excl"}, a0 & a1, 1'b0);
        check({who, "_ack_expected"}, have, 1'b1);
        if (have) begin
            check({who, "_port"}, a1, e.port);
            check({who, "_addr"}, maddr, e.addr);
            check({who, "_we"}, mwe, e.we);
            check({who, "_wdata"}, mwd, e.wdata);
            check({who, "_rdata"}, a1 ? r1 : r0, e.rdata);
        end
    endtask

    // Every ack consumes exactly one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (!rst) begin
            if (rr_ack0 || rr_ack1) begin
                have = (q_rr.size() > 0);
                if (have) e = q_rr.pop_front();
                check_ack("rr", rr_ack0, rr_ack1, rr_mem_addr, rr_mem_we, rr_mem_wdata,
                          rr_rdata0, rr_rdata1, have, e);
            end
            if (fp_ack0 || fp_ack1) begin
                have = (q_fp.size() > 0);
                if (have) e = q_fp.pop_front();
                check_ack("fp", fp_ack0, fp_ack1, fp_mem_addr, fp_mem_we, fp_mem_wdata,
                          fp_rdata0, fp_rdata1, have, e);
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_rr_req"}, rr_mem_req, 1'b0);
        check({tag, "_fp_req"}, fp_mem_req, 1'b0);
        check({tag, "_rr_ack"}, {rr_ack0, rr_ack1}, 2'b00);
        check({tag, "_fp_ack"}, {fp_ack0, fp_ack1}, 2'b00);
    endtask

    // Called with both arbiters IDLE, requests already driven for the next arbitration edge.
    task automatic txn(input int lat, input logic [31:0] rd, input bit raise1);
        logic wr, wf;
        wr = model_win(req0, req1, m_last_rr, 1'b0);
        wf = model_win(req0, req1, m_last_fp, 1'b1);
        q_rr.push_back(mk(wr, rd));
        q_fp.push_back(mk(wf, rd));
        @(posedge clk); #1;
        if (raise1) req1 = 1'b1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("busy_rr_req", rr_mem_req, 1'b1);
            check("busy_fp_req", fp_mem_req, 1'b1);
            check("early_ack", {rr_ack0, rr_ack1, fp_ack0, fp_ack1}, 4'b0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        check("ready_rr_req", rr_mem_req, 1'b1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        m_last_rr = wr;
        m_last_fp = wf;
        @(negedge clk);
        check_idle("gap");
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b1; we1 = 1'b0;
        addr0 = 32'h100; addr1 = 32'h200; wdata0 = 32'h0A0A_0A0A; wdata1 = 32'h1B1B_1B1B;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        m_last_rr = 1'b1; m_last_fp = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_rr_we", rr_mem_we, 1'b0);
        check("reset_fp_we", fp_mem_we, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; we0 = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // Reset held three cycles in the middle of a port-1 transaction: abandoned, no ack.
        req1 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_busy", rr_mem_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; req1 = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        check_idle("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check_idle("rst_release");
        m_last_rr = 1'b1; m_last_fp = 1'b1;

        // Both ports contending: round-robin alternates from port 0, fixed priority keeps port 1.
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) txn(i % 3, $urandom, 1'b0);
        req1 = 1'b0;
        txn(1, 32'h1234_5678, 1'b0);
        req0 = 1'b0;

        // Lone fetch, memory answers three cycles after mem_req.
        addr0 = 32'h100; req0 = 1'b1;
        txn(3, 32'hCAFE_F00D, 1'b0);
        req0 = 1'b0;

        // LSU write.
        req1 = 1'b1; we1 = 1'b1; wdata1 = 32'hDEAD_BEEF; addr1 = 32'h0000_0F00;
        txn(2, 32'h5555_AAAA, 1'b0);
        req1 = 1'b0; we1 = 1'b0;

        // Stray mem_ready while idle, then port 1 arriving during a port-0 transaction.
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle("idle_ready");
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        addr0 = 32'h140; req0 = 1'b1;
        txn(2, 32'h0BAD_F00D, 1'b1);
        req0 = 1'b0;
        txn(1, 32'h7777_0001, 1'b0);
        req1 = 1'b0;

        repeat (3) @(negedge clk);
        check("rr_queue_drained", q_rr.size(), 0);
        check("fp_queue_drained", q_fp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
